// File: rtl/apu_frame_ctrl.sv
// apu_frame_ctrl: $4017 write capture with delayed apply, $4015 read-clear, frame IRQ flag.
// Optional APU_FRAME_CTRL_DMC_IRQ_EN adds a dmc_irq input merged into irq_n.
module apu_frame_ctrl #(
  parameter int unsigned WRITE_DELAY = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       apu_clk_pulse,
  input  logic       wr_4017,
  input  logic [1:0] wr_data,
  input  logic       rd_4015,
  input  logic       f_pulse,
`ifdef APU_FRAME_CTRL_DMC_IRQ_EN
  input  logic       dmc_irq,
`endif
  output logic [1:0] fc_to_apu,
  output logic       fc_mode_wren,
  output logic       e_imm,
  output logic       l_imm,
  output logic       frame_irq,
  output logic       irq_n,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, DELAY, APPLY} state_t;
  localparam logic [3:0] DLY = 4'(WRITE_DELAY);
  state_t     r_state;
  logic       r_wr_prev, r_rd_prev, r_inhibit;
  logic [1:0] r_hold;
  logic [3:0] r_cnt;
  logic       w_wr_rise, w_rd_fall, w_go, w_irq_next, w_irq_any;
  assign w_wr_rise  = wr_4017 & ~r_wr_prev;
  assign w_rd_fall  = ~rd_4015 & r_rd_prev;
  assign w_go       = (r_state == DELAY) && ((r_cnt == 4'd0) || (apu_clk_pulse && r_cnt == 4'd1));
  // set beats clear when both land in the same clk
  assign w_irq_next = (f_pulse & ~r_inhibit) | (frame_irq & ~(w_rd_fall | (w_wr_rise & wr_data[0])));
`ifdef APU_FRAME_CTRL_DMC_IRQ_EN
  assign w_irq_any  = w_irq_next | dmc_irq;
`else
  assign w_irq_any  = w_irq_next;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_wr_prev    <= 1'b0;
      r_rd_prev    <= 1'b0;
      r_inhibit    <= 1'b1;
      r_hold       <= 2'b00;
      r_cnt        <= 4'd0;
      fc_to_apu    <= 2'b01;
      fc_mode_wren <= 1'b0;
      e_imm        <= 1'b0;
      l_imm        <= 1'b0;
      frame_irq    <= 1'b0;
      irq_n        <= 1'b1;
      busy         <= 1'b0;
    end else begin
      r_wr_prev    <= wr_4017;
      r_rd_prev    <= rd_4015;
      fc_mode_wren <= 1'b0;
      e_imm        <= 1'b0;
      l_imm        <= 1'b0;
      frame_irq    <= w_irq_next;
      irq_n        <= ~w_irq_any;
      // a new capture always discards any pending write, even in the apply clk
      if (w_wr_rise) begin
        r_hold  <= wr_data;
        r_cnt   <= DLY;
        r_state <= DELAY;
        busy    <= 1'b1;
      end else if (w_go) begin
        r_state      <= APPLY;
        fc_to_apu    <= r_hold;
        fc_mode_wren <= 1'b1;
        e_imm        <= r_hold[1];
        l_imm        <= r_hold[1];
        r_inhibit    <= r_hold[0];
      end else if (r_state == APPLY) begin
        r_state <= IDLE;
        busy    <= 1'b0;
      end else if (r_state == DELAY && apu_clk_pulse) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end
endmodule

// File: doc/apu_frame_ctrl.md
Name: apu_frame_ctrl

Overview:
- Controller for the APU frame counter: decodes CPU writes to $4017 and reads of $4015, applies mode/IRQ-inhibit changes after a programmable APU-cycle delay, and owns the frame IRQ flag.
- Sits between the CPU register decode and the frame counter.
- Drives the frame counter's to_apu/mode_wren inputs and produces the immediate quarter/half-frame clocks that a mode-1 write requires.
- Consumes the frame counter's f_pulse to set the frame IRQ.

Parameters:
- WRITE_DELAY, 2: number of apu_clk_pulse events between write capture and apply; legal range 0..15, held in a 4-bit counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- apu_clk_pulse  in  1  one-clk pulse per APU cycle
- wr_4017  in  1  $4017 write strobe, level, may be high for several clks
- wr_data  in  2  CPU data bits [7:6]; [1] = sequence mode, [0] = IRQ inhibit
- rd_4015  in  1  $4015 read strobe, level, may be high for several clks
- f_pulse  in  1  frame pulse from the frame counter
- fc_to_apu  out  2  mode bits to the frame counter
- fc_mode_wren  out  1  one-clk write strobe to the frame counter
- e_imm  out  1  immediate envelope clock, ORed with the frame counter's e_pulse
- l_imm  out  1  immediate length clock, ORed with the frame counter's l_pulse
- frame_irq  out  1  IRQ flag, also $4015 bit 6
- irq_n  out  1  active-low IRQ to the CPU
- busy  out  1  high while a write is pending

Behaviour:
- Reset (rst low, async), all registered:
  - fc_to_apu=2'b01, fc_mode_wren=0, e_imm=0, l_imm=0, frame_irq=0, irq_n=1, busy=0.
  - inhibit copy=1, state=IDLE, delay count=0.
- Edge detection: wr_4017 and rd_4015 are edge-detected with registered previous values. Previous values reset to 0.
- Write capture (rising edge of wr_4017):
  - Latch wr_data into hold, load delay count=WRITE_DELAY, go to DELAY, busy=1.
  - If wr_data[0]=1, clear frame_irq on the same clk. The clear is immediate, not delayed.
  - The inhibit copy updates only at apply.
- States:
  - IDLE: wait for a write capture.
  - DELAY: on each apu_clk_pulse, decrement count. When count==1 with apu_clk_pulse, or count==0 on entry, go to APPLY on the next clk.
  - APPLY: one clk only.
    - fc_to_apu=hold, fc_mode_wren=1, inhibit copy=hold[0].
    - If hold[1]=1, also e_imm=1 and l_imm=1 in the same clk.
    - Then go to IDLE, busy=0.
- Output widths:
  - fc_mode_wren, e_imm and l_imm are exactly one clk wide.
  - fc_to_apu holds its value between writes.
- New write while busy: re-latch hold, reload count, stay in DELAY. The earlier write is discarded and never applied. A write captured in the APPLY clk also re-enters DELAY.
- IRQ flag:
  - Set on f_pulse when the inhibit copy is 0.
  - Cleared on the falling edge of rd_4015, so the read returns the set value.
  - Cleared by a capture with wr_data[0]=1.
  - Set and clear in the same clk: set wins.
- irq_n=~frame_irq, registered, so it lags frame_irq by 0 clks (same register stage).
- Reset asserted mid-DELAY: the pending write is lost. No fc_mode_wren after reset release.

Optional Feature:
- Macro APU_FRAME_CTRL_DMC_IRQ_EN.
- When defined:
  - Adds input dmc_irq (1 bit, level).
  - irq_n = ~(frame_irq | dmc_irq), registered.
  - dmc_irq does not affect frame_irq and is not cleared by this block.
- When undefined: no dmc_irq port; irq_n = ~frame_irq.

Test Plan:
- Reset then write 2'b10 (WRITE_DELAY=2), wr_4017 held 3 clks -> exactly one capture. After 2 apu_clk_pulses: fc_mode_wren=1 for one clk, fc_to_apu=2'b10, e_imm=l_imm=1 in that clk, busy falls on the next clk.
- Write 2'b00 with inhibit previously 0, then f_pulse -> frame_irq=1, irq_n=0. Hold rd_4015 4 clks -> frame_irq stays 1 until the clk after rd_4015 falls, then 0.
- frame_irq=1, write 2'b01 -> frame_irq=0 on the capture clk, before apply. A later f_pulse after apply leaves frame_irq=0.
- Write 2'b10, then write 2'b00 one apu_clk_pulse later -> single fc_mode_wren with fc_to_apu=2'b00, e_imm=l_imm=0, apply 2 pulses after the second capture.
- Simultaneous f_pulse and rd_4015 falling edge, inhibit=0 -> frame_irq=1 (set wins). Pulse rst low mid-DELAY -> no fc_mode_wren, fc_to_apu=2'b01.
- With APU_FRAME_CTRL_DMC_IRQ_EN: dmc_irq=1, frame_irq=0 -> irq_n=0. rd_4015 edge -> irq_n stays 0 until dmc_irq=0.
